// File: rtl/wb_stage_ext.sv
// MEM/WB pipeline register with load extraction and write-back value selection.
// Optional retire counter (wb_retire_cnt) enabled by defining WB_RETIRE_CNT_EN.
module wb_stage_ext #(
    parameter int               XLEN     = 32,
    parameter int               REG_AW   = 5,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic [31:0]       mem_instr,
    input  logic [XLEN-1:0]   mem_pc,
    input  logic [REG_AW-1:0] mem_dstreg_num,
    input  logic              mem_reg_we,
    input  logic [1:0]        mem_wb_sel,
    input  logic [XLEN-1:0]   mem_alu_result,
    input  logic [2:0]        mem_load_funct3,
    input  logic [2:0]        mem_load_addr_lo,
    input  logic [XLEN-1:0]   mem_load_value,
    input  logic              wb_stall,
    input  logic              wb_flush,
    output logic              wb_valid,
    output logic [31:0]       wb_instr,
    output logic [XLEN-1:0]   wb_pc,
    output logic [REG_AW-1:0] wb_dstreg_num,
    output logic [XLEN-1:0]   wb_dstreg_value,
`ifdef WB_RETIRE_CNT_EN
    output logic              wb_reg_we,
    output logic [63:0]       wb_retire_cnt
`else
    output logic              wb_reg_we
`endif
);

    logic              valid_q, valid_d;
    logic              reg_we_q, reg_we_d;
    logic [31:0]       instr_q, instr_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [REG_AW-1:0] dst_q, dst_d;
    logic [1:0]        sel_q, sel_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [2:0]        addr_lo_q, addr_lo_d;
    logic [XLEN-1:0]   load_q, load_d;

    // The link value replaces the ALU result at capture, so WB only muxes ALU vs load.
    always_comb begin
        valid_d   = valid_q;
        reg_we_d  = reg_we_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        dst_d     = dst_q;
        sel_d     = sel_q;
        res_d     = res_q;
        funct3_d  = funct3_q;
        addr_lo_d = addr_lo_q;
        load_d    = load_q;
        if (wb_flush) begin
            valid_d  = 1'b0;
            reg_we_d = 1'b0;
        end else if (!wb_stall) begin
            valid_d   = mem_valid;
            reg_we_d  = mem_reg_we;
            instr_d   = mem_instr;
            pc_d      = mem_pc;
            dst_d     = mem_dstreg_num;
            sel_d     = mem_wb_sel;
            res_d     = (mem_wb_sel == 2'b10) ? mem_pc + XLEN'(4) : mem_alu_result;
            funct3_d  = mem_load_funct3;
            addr_lo_d = mem_load_addr_lo;
            load_d    = mem_load_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            reg_we_q  <= 1'b0;
            instr_q   <= 32'h0000_0013;
            pc_q      <= RESET_PC;
            dst_q     <= '0;
            sel_q     <= 2'b00;
            res_q     <= '0;
            funct3_q  <= 3'b000;
            addr_lo_q <= 3'b000;
            load_q    <= '0;
        end else begin
            valid_q   <= valid_d;
            reg_we_q  <= reg_we_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            dst_q     <= dst_d;
            sel_q     <= sel_d;
            res_q     <= res_d;
            funct3_q  <= funct3_d;
            addr_lo_q <= addr_lo_d;
            load_q    <= load_d;
        end
    end

    logic [5:0]      byte_sh, half_sh, word_sh;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [31:0]     word_v;
    logic [XLEN-1:0] word_sx, word_zx;
    logic [XLEN-1:0] load_ext;

    // Lane offsets; at XLEN=32 the top offset bit has no lane to select.
    always_comb begin
        if (XLEN == 64) begin
            byte_sh = {addr_lo_q, 3'b000};
            half_sh = {addr_lo_q[2:1], 4'b0000};
            word_sh = {addr_lo_q[2], 5'b00000};
        end else begin
            byte_sh = {1'b0, addr_lo_q[1:0], 3'b000};
            half_sh = {1'b0, addr_lo_q[1], 4'b0000};
            word_sh = 6'd0;
        end
        byte_v = 8'(load_q >> byte_sh);
        half_v = 16'(load_q >> half_sh);
        word_v = 32'(load_q >> word_sh);
    end

    generate
        if (XLEN == 64) begin : g_word64
            assign word_sx = {{(XLEN-32){word_v[31]}}, word_v};
            assign word_zx = {{(XLEN-32){1'b0}}, word_v};
        end else begin : g_word32
            assign word_sx = word_v;
            assign word_zx = word_v;
        end
    endgenerate

    always_comb begin
        load_ext = load_q;
        case (funct3_q)
            3'b000:  load_ext = {{(XLEN-8){byte_v[7]}}, byte_v};
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, byte_v};
            3'b001:  load_ext = {{(XLEN-16){half_v[15]}}, half_v};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, half_v};
            3'b010:  load_ext = word_sx;
            3'b110:  load_ext = (XLEN == 64) ? word_zx : word_sx;
            3'b011:  load_ext = (XLEN == 64) ? load_q : word_sx;
            default: load_ext = load_q;
        endcase
    end

    assign wb_valid        = valid_q;
    assign wb_instr        = instr_q;
    assign wb_pc           = pc_q;
    assign wb_dstreg_num   = dst_q;
    assign wb_dstreg_value = (sel_q == 2'b01) ? load_ext : res_q;
    assign wb_reg_we       = valid_q & reg_we_q & (dst_q != '0);

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt_q, retire_cnt_d;

    // Counts only edges that actually retire a real instruction into WB.
    always_comb begin
        retire_cnt_d = retire_cnt_q + 64'(mem_valid & ~wb_flush & ~wb_stall);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign wb_retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage_ext.sv
// Scoreboard bench for wb_stage_ext (XLEN=32): directed vectors queue expected WB state,
// a negedge monitor pops and compares. Retire-counter checks run when WB_RETIRE_CNT_EN is defined.
module tb_wb_stage_ext;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  dst;
        logic        we;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [2:0]  f3;
        logic [2:0]  alo;
        logic [31:0] ld;
    } stim_t;

    typedef struct {
        string       name;
        int          tgt;
        logic        valid;
        logic        we;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  dst;
        logic [31:0] value;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_instr;
    logic [31:0] mem_pc;
    logic [4:0]  mem_dstreg_num;
    logic        mem_reg_we;
    logic [1:0]  mem_wb_sel;
    logic [31:0] mem_alu_result;
    logic [2:0]  mem_load_funct3;
    logic [2:0]  mem_load_addr_lo;
    logic [31:0] mem_load_value;
    logic        wb_stall;
    logic        wb_flush;
    logic        wb_valid;
    logic [31:0] wb_instr;
    logic [31:0] wb_pc;
    logic [4:0]  wb_dstreg_num;
    logic [31:0] wb_dstreg_value;
    logic        wb_reg_we;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] wb_retire_cnt;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    exp_t sb[$];

    wb_stage_ext #(.XLEN(32), .REG_AW(5), .RESET_PC(32'h0)) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_valid        (mem_valid),
        .mem_instr        (mem_instr),
        .mem_pc           (mem_pc),
        .mem_dstreg_num   (mem_dstreg_num),
        .mem_reg_we       (mem_reg_we),
        .mem_wb_sel       (mem_wb_sel),
        .mem_alu_result   (mem_alu_result),
        .mem_load_funct3  (mem_load_funct3),
        .mem_load_addr_lo (mem_load_addr_lo),
        .mem_load_value   (mem_load_value),
        .wb_stall         (wb_stall),
        .wb_flush         (wb_flush),
        .wb_valid         (wb_valid),
        .wb_instr         (wb_instr),
        .wb_pc            (wb_pc),
        .wb_dstreg_num    (wb_dstreg_num),
        .wb_dstreg_value  (wb_dstreg_value),
`ifdef WB_RETIRE_CNT_EN
        .wb_retire_cnt    (wb_retire_cnt),
`endif
        .wb_reg_we        (wb_reg_we)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'h0000_0033;
    endfunction

    function automatic stim_t mk(input logic v, input logic [31:0] pc, input logic [4:0] dst,
                                 input logic we, input logic [1:0] sel, input logic [31:0] alu,
                                 input logic [2:0] f3, input logic [2:0] alo, input logic [31:0] ld);
        stim_t s;
        s.rst = 1'b0; s.stall = 1'b0; s.flush = 1'b0;
        s.valid = v; s.instr = instr_of(pc); s.pc = pc; s.dst = dst; s.we = we;
        s.sel = sel; s.alu = alu; s.f3 = f3; s.alo = alo; s.ld = ld;
        return s;
    endfunction

    function automatic exp_t ex(input string n, input logic v, input logic we,
                                input logic [31:0] pc, input logic [4:0] dst, input logic [31:0] value);
        exp_t e;
        e.name = n; e.tgt = 0; e.valid = v; e.we = we; e.instr = instr_of(pc);
        e.pc = pc; e.dst = dst; e.value = value;
        return e;
    endfunction

    // Drives one cycle of MEM inputs and queues the WB state expected after the next edge.
    task automatic applyStimulus(input stim_t s, input exp_t e);
        rst              = s.rst;
        wb_stall         = s.stall;
        wb_flush         = s.flush;
        mem_valid        = s.valid;
        mem_instr        = s.instr;
        mem_pc           = s.pc;
        mem_dstreg_num   = s.dst;
        mem_reg_we       = s.we;
        mem_wb_sel       = s.sel;
        mem_alu_result   = s.alu;
        mem_load_funct3  = s.f3;
        mem_load_addr_lo = s.alo;
        mem_load_value   = s.ld;
        e.tgt = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("[TB] FAIL %s.%s actual=%08h required=%08h", n, f, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        cmp(e.name, "wb_valid",  32'(wb_valid),      32'(e.valid));
        cmp(e.name, "wb_reg_we", 32'(wb_reg_we),     32'(e.we));
        cmp(e.name, "wb_instr",  wb_instr,           e.instr);
        cmp(e.name, "wb_pc",     wb_pc,              e.pc);
        cmp(e.name, "wb_dst",    32'(wb_dstreg_num), 32'(e.dst));
        cmp(e.name, "wb_value",  wb_dstreg_value,    e.value);
    endtask

    // Monitor: pops every expectation whose target edge has passed.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].tgt <= cyc) begin
            checkOutput(sb.pop_front());
        end
    end

    initial begin
        stim_t s;
        exp_t  r;
        localparam logic [31:0] RAW = 32'h80F0_7F81;

        r = ex("reset", 1'b0, 1'b0, 32'h0, 5'd0, 32'h0);
        r.instr = 32'h0000_0013;
        for (int i = 0; i < 2; i++) begin
            s = mk(1'($urandom), $urandom, 5'($urandom), 1'($urandom), 2'($urandom),
                   $urandom, 3'($urandom), 3'($urandom), $urandom);
            s.rst = 1'b1; s.stall = 1'($urandom); s.flush = 1'($urandom);
            applyStimulus(s, r);
        end

        applyStimulus(mk(1, 32'h100, 5, 1, 2'b00, 32'h1234, 3'b000, 3'b000, 32'h0),
                      ex("alu", 1, 1, 32'h100, 5, 32'h1234));
        applyStimulus(mk(1, 32'h104, 0, 1, 2'b00, 32'h5555, 3'b000, 3'b000, 32'h0),
                      ex("alu_x0", 1, 0, 32'h104, 0, 32'h5555));
        applyStimulus(mk(1, 32'h108, 6, 1, 2'b01, 32'hDEAD, 3'b000, 3'b000, RAW),
                      ex("lb0", 1, 1, 32'h108, 6, 32'hFFFF_FF81));
        applyStimulus(mk(1, 32'h10C, 6, 1, 2'b01, 32'hDEAD, 3'b000, 3'b001, RAW),
                      ex("lb1", 1, 1, 32'h10C, 6, 32'h0000_007F));
        applyStimulus(mk(1, 32'h110, 7, 1, 2'b01, 32'hDEAD, 3'b100, 3'b011, RAW),
                      ex("lbu3", 1, 1, 32'h110, 7, 32'h0000_0080));
        applyStimulus(mk(1, 32'h114, 8, 1, 2'b01, 32'hDEAD, 3'b001, 3'b010, RAW),
                      ex("lh2", 1, 1, 32'h114, 8, 32'hFFFF_80F0));
        applyStimulus(mk(1, 32'h118, 8, 1, 2'b01, 32'hDEAD, 3'b101, 3'b000, RAW),
                      ex("lhu0", 1, 1, 32'h118, 8, 32'h0000_7F81));
        applyStimulus(mk(1, 32'h11C, 8, 1, 2'b01, 32'hDEAD, 3'b101, 3'b011, RAW),
                      ex("lhu3_misal", 1, 1, 32'h11C, 8, 32'h0000_80F0));
        applyStimulus(mk(1, 32'h120, 9, 1, 2'b01, 32'hDEAD, 3'b010, 3'b000, RAW),
                      ex("lw", 1, 1, 32'h120, 9, 32'h80F0_7F81));
        applyStimulus(mk(1, 32'h124, 9, 1, 2'b01, 32'hDEAD, 3'b100, 3'b100, RAW),
                      ex("lbu4_ign_bit2", 1, 1, 32'h124, 9, 32'h0000_0081));
        applyStimulus(mk(1, 32'h128, 9, 1, 2'b01, 32'hDEAD, 3'b111, 3'b010, RAW),
                      ex("raw111", 1, 1, 32'h128, 9, 32'h80F0_7F81));
        applyStimulus(mk(1, 32'hFFFF_FFFC, 1, 1, 2'b10, 32'hDEAD, 3'b000, 3'b000, RAW),
                      ex("link_wrap", 1, 1, 32'hFFFF_FFFC, 1, 32'h0));
        applyStimulus(mk(1, 32'h300, 1, 1, 2'b10, 32'hDEAD, 3'b000, 3'b000, RAW),
                      ex("link", 1, 1, 32'h300, 1, 32'h304));
        applyStimulus(mk(1, 32'h130, 2, 1, 2'b11, 32'hABCD, 3'b000, 3'b000, RAW),
                      ex("sel11", 1, 1, 32'h130, 2, 32'hABCD));
        applyStimulus(mk(0, 32'h134, 7, 1, 2'b00, 32'h7777, 3'b000, 3'b000, RAW),
                      ex("invalid", 0, 0, 32'h134, 7, 32'h7777));

        applyStimulus(mk(1, 32'h200, 9, 1, 2'b00, 32'h9999, 3'b000, 3'b000, RAW),
                      ex("pre_stall", 1, 1, 32'h200, 9, 32'h9999));
        for (int i = 0; i < 3; i++) begin
            s = mk(1, 32'h300 + 32'(i * 4), 3, 1, 2'b01, 32'h3333, 3'b000, 3'b001, RAW);
            s.stall = 1'b1;
            applyStimulus(s, ex("stall", 1, 1, 32'h200, 9, 32'h9999));
        end
        s = mk(1, 32'h400, 4, 1, 2'b00, 32'h4444, 3'b000, 3'b000, RAW);
        s.stall = 1'b1; s.flush = 1'b1;
        applyStimulus(s, ex("stall_flush", 0, 0, 32'h200, 9, 32'h9999));
        s.flush = 1'b0;
        applyStimulus(s, ex("stall_after_flush", 0, 0, 32'h200, 9, 32'h9999));
        applyStimulus(mk(1, 32'h300, 3, 1, 2'b00, 32'h3333, 3'b000, 3'b000, RAW),
                      ex("resume", 1, 1, 32'h300, 3, 32'h3333));

`ifdef WB_RETIRE_CNT_EN
        s = mk(0, 32'h0, 0, 0, 2'b00, 32'h0, 3'b000, 3'b000, 32'h0);
        s.rst = 1'b1;
        applyStimulus(s, r);
        s = mk(1, 32'h10, 1, 1, 2'b00, 32'h1, 3'b000, 3'b000, 32'h0);
        for (int i = 0; i < 10; i++) applyStimulus(s, ex("cnt_run", 1, 1, 32'h10, 1, 32'h1));
        s.stall = 1'b1;
        for (int i = 0; i < 2; i++) applyStimulus(s, ex("cnt_stall", 1, 1, 32'h10, 1, 32'h1));
        s.stall = 1'b0; s.flush = 1'b1;
        applyStimulus(s, ex("cnt_flush", 0, 0, 32'h10, 1, 32'h1));
        s.flush = 1'b0; s.valid = 1'b0;
        applyStimulus(s, ex("cnt_invalid", 0, 0, 32'h10, 1, 32'h1));
        n_cmp++;
        if (wb_retire_cnt !== 64'd10) begin
            n_bad++;
            $display("[TB] FAIL retire_cnt actual=%0d required=10", wb_retire_cnt);
        end
        s.rst = 1'b1;
        applyStimulus(s, r);
        n_cmp++;
        if (wb_retire_cnt !== 64'd0) begin
            n_bad++;
            $display("[TB] FAIL retire_cnt_reset actual=%0d required=0", wb_retire_cnt);
        end
`endif

        rst = 1'b0; wb_stall = 1'b0; wb_flush = 1'b0; mem_valid = 1'b0;
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL drain pending=%0d required=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
